cordic_trig_sequencer: RTL and testbench

- Upstream request stage for the CORDIC sine core.
- Accepts full-range angle requests [-pi, pi] with a sine/cosine op select over a valid/ready handshake.
- Folds each angle into the core's legal range [-pi/2, pi/2], issues one core transaction, and captures the result.
- Returns the result on a valid/ready output with a status code, adding range checking and a done-timeout watchdog.

---
 rtl/cordic_trig_sequencer.sv | 149 ++++++++++++++
 tb/tb_cordic_trig_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_trig_sequencer.sv
// Request sequencer for the CORDIC sine core: folds [-pi, pi] sine/cosine requests into the
// core's [-pi/2, pi/2] range, runs one core transaction and returns the result with a status.
module cordic_trig_sequencer #(
    parameter int unsigned BIT_WIDTH      = 32,
    parameter int unsigned FRAC_BITS      = 29,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [BIT_WIDTH-1:0] in_angle,
    input  logic                        in_op,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [BIT_WIDTH-1:0] out_value,
    output logic [1:0]                  out_status,
    output logic                        core_start,
    output logic signed [BIT_WIDTH-1:0] core_angle,
    input  logic                        core_ready,
    input  logic                        core_done,
    input  logic signed [BIT_WIDTH-1:0] core_value
);
    localparam int unsigned W2   = BIT_WIDTH + 2;
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic signed [W2-1:0] PiQ =
        W2'(longint'(3.141592653589793 * (2.0 ** FRAC_BITS)));
    localparam logic signed [W2-1:0] HalfPiQ = PiQ >>> 1;
    localparam logic signed [W2-1:0] TwoPiQ  = PiQ <<< 1;

    localparam logic [1:0] StatusOk      = 2'b00;
    localparam logic [1:0] StatusRange   = 2'b01;
    localparam logic [1:0] StatusTimeout = 2'b10;

    typedef enum logic [2:0] {
        StIdle, StReduce, StWaitReady, StIssue, StWaitDone, StOutput
    } state_e;

    state_e                        r_state;
    state_e                        w_state_d;
    logic signed [BIT_WIDTH-1:0]   r_angle;
    logic                          r_op;
    logic signed [BIT_WIDTH-1:0]   r_core_angle;
    logic                          r_core_start;
    logic                          r_done_q;
    logic [CntW-1:0]               r_cnt;
    logic signed [BIT_WIDTH-1:0]   r_out_value;
    logic [1:0]                    r_out_status;

    logic signed [W2-1:0]          w_angle_ext;
    logic signed [W2-1:0]          w_a0;
    logic signed [W2-1:0]          w_a1;
    logic signed [W2-1:0]          w_a2;
    logic                          w_range_err;
    logic                          w_done_edge;
    logic                          w_timeout;
    logic                          w_unused_hi;

    // Angle reduction, evaluated on the latched request.
    always_comb begin
        w_angle_ext = {{2{r_angle[BIT_WIDTH-1]}}, r_angle};
        w_range_err = (w_angle_ext < -PiQ) || (w_angle_ext > PiQ);
        w_a0 = r_op ? (w_angle_ext + HalfPiQ) : w_angle_ext;
        w_a1 = (w_a0 > PiQ) ? (w_a0 - TwoPiQ) : w_a0;
        if (w_a1 > HalfPiQ) begin
            w_a2 = PiQ - w_a1;
        end else if (w_a1 < -HalfPiQ) begin
            w_a2 = -PiQ - w_a1;
        end else begin
            w_a2 = w_a1;
        end
    end

    assign w_unused_hi = ^w_a2[W2-1:BIT_WIDTH];
    assign w_done_edge = core_done & ~r_done_q;
    assign w_timeout   = (r_cnt == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_state_d = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) w_state_d = StReduce;
            end
            StReduce:    w_state_d = w_range_err ? StOutput : StWaitReady;
            StWaitReady: if (core_ready) w_state_d = StIssue;
            StIssue:     w_state_d = StWaitDone;
            StWaitDone:  if (w_done_edge || w_timeout) w_state_d = StOutput;
            StOutput: begin
                out_valid = 1'b1;
                if (out_ready) w_state_d = StIdle;
            end
            default:     w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_angle      <= '0;
            r_op         <= 1'b0;
            r_core_angle <= '0;
            r_core_start <= 1'b0;
            r_done_q     <= 1'b0;
            r_cnt        <= '0;
            r_out_value  <= '0;
            r_out_status <= StatusOk;
        end else begin
            r_state      <= w_state_d;
            r_done_q     <= core_done;
            // Registered pulse that coincides exactly with the ISSUE cycle.
            r_core_start <= (w_state_d == StIssue);
            if (r_state == StIdle && in_valid) begin
                r_angle <= in_angle;
                r_op    <= in_op;
            end
            if (r_state == StReduce) begin
                if (w_range_err) begin
                    r_out_value  <= '0;
                    r_out_status <= StatusRange;
                end else begin
                    r_core_angle <= w_a2[BIT_WIDTH-1:0];
                end
            end
            if (r_state == StIssue) begin
                r_cnt <= '0;
            end else if (r_state == StWaitDone) begin
                if (w_done_edge) begin
                    r_out_value  <= core_value;
                    r_out_status <= StatusOk;
                end else if (w_timeout) begin
                    r_out_value  <= '0;
                    r_out_status <= StatusTimeout;
                end else begin
                    r_cnt <= r_cnt + CntW'(1);
                end
            end
        end
    end

    assign out_value  = r_out_value;
    assign out_status = r_out_status;
    assign core_start = r_core_start;
    assign core_angle = r_core_angle;

endmodule

// File: tb/tb_cordic_trig_sequencer.sv
// Self-checking bench for cordic_trig_sequencer: directed vector table, timeout/stall/reset
// sequences and randomized requests against an arithmetic reference model.
module tb_cordic_trig_sequencer;
    localparam longint PI_Q     = 64'sd1686629713;
    localparam longint HALF_PI  = 64'sd843314856;
    localparam longint TWO_PI   = 64'sd3373259426;
    localparam int     TIMEOUT  = 64;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] in_angle;
    logic               in_op;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] out_value;
    logic [1:0]         out_status;
    logic               core_start;
    logic signed [31:0] core_angle;
    logic               core_ready;
    logic               core_done;
    logic signed [31:0] core_value;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cordic_trig_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_angle   (in_angle),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_value  (out_value),
        .out_status (out_status),
        .core_start (core_start),
        .core_angle (core_angle),
        .core_ready (core_ready),
        .core_done  (core_done),
        .core_value (core_value)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", nm, $signed(act), act,
                     $signed(exp), exp);
        end
    endtask

    // Fold the phase (angle + op*pi/2) into (-pi, pi], then mirror into [-pi/2, pi/2].
    function automatic longint ref_fold(input bit op, input longint ang);
        longint ph;
        ph = ang + (op ? HALF_PI : 64'sd0);
        while (ph > PI_Q) ph = ph - TWO_PI;
        if (ph > HALF_PI) ph = PI_Q - ph;
        if (ph < -HALF_PI) ph = -PI_Q - ph;
        return ph;
    endfunction

    function automatic bit ref_in_range(input longint ang);
        return (ang >= -PI_Q) && (ang <= PI_Q);
    endfunction

    // Runs one request from IDLE, playing the sine core. done_dly < 0 means no done pulse.
    task automatic do_request(
        input  logic        op,
        input  logic [31:0] ang,
        input  int          ready_dly,
        input  int          done_dly,
        input  logic        pre_done,
        input  logic [31:0] val,
        input  int          stall,
        input  logic        nxt_valid,
        input  logic        nxt_op,
        input  logic [31:0] nxt_ang,
        output logic [31:0] got_angle,
        output int          starts,
        output logic [31:0] got_value,
        output logic [1:0]  got_status,
        output int          lat,
        output int          issue_n
    );
        int n;
        int cd;
        starts = 0; got_angle = '0; got_value = '0; got_status = '0; lat = -1; issue_n = -1;
        cd = -1;
        chk("idle_in_ready", {31'b0, in_ready}, 32'd1);
        in_valid   = 1'b1;
        in_op      = op;
        in_angle   = ang;
        core_value = val;
        core_ready = (ready_dly == 0);
        core_done  = pre_done;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        chk("busy_in_ready", {31'b0, in_ready}, 32'd0);
        while (!out_valid && n < 300) begin
            if (!pre_done) core_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) core_done = 1'b1;
            end
            if (core_start) begin
                starts++;
                got_angle = core_angle;
                issue_n   = n;
                cd        = done_dly;
            end
            if (n >= 2 + ready_dly) core_ready = 1'b1;
            @(negedge clk);
            n++;
        end
        core_done = 1'b0;
        if (!out_valid) begin
            checks++;
            failures++;
            $display("FAIL out_valid_watchdog: no out_valid within %0d cycles", n);
        end else begin
            lat        = n;
            got_value  = out_value;
            got_status = out_status;
            for (int s = 0; s < stall; s++) begin
                in_valid = nxt_valid;
                in_op    = nxt_op;
                in_angle = nxt_ang;
                @(negedge clk);
                chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
                chk("stall_out_value", out_value, got_value);
                chk("stall_out_status", {30'b0, out_status}, {30'b0, got_status});
                chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk("post_hs_out_valid", {31'b0, out_valid}, 32'd0);
            chk("post_hs_in_ready", {31'b0, in_ready}, 32'd1);
        end
    endtask

    typedef struct {
        logic        op;
        logic [31:0] ang;
        logic [31:0] exp_angle;
        logic [1:0]  exp_status;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] ga;
        logic [31:0] gv;
        logic [1:0]  gs;
        int          st;
        int          lt;
        int          isn;
        int          seen;
        longint      sang;
        logic [31:0] ra;
        logic        rop;
        logic [31:0] rval;
        int          rd;
        int          dd;
        bit          ok;

        vecs[0] = '{1'b0, 32'd1264972285, 32'd421657428, 2'd0};
        vecs[1] = '{1'b1, 32'd1686629713, -32'sd843314856, 2'd0};
        vecs[2] = '{1'b1, 32'd0, 32'd843314856, 2'd0};
        vecs[3] = '{1'b0, -32'sd1686629713, 32'd0, 2'd0};
        vecs[4] = '{1'b0, 32'd1700000000, 32'd0, 2'd1};
        vecs[5] = '{1'b0, -32'sd1686629714, 32'd0, 2'd1};
        vecs[6] = '{1'b1, -32'sd1686629713, -32'sd843314856, 2'd0};
        vecs[7] = '{1'b0, 32'd843314856, 32'd843314856, 2'd0};
        vecs[8] = '{1'b0, 32'd843314857, 32'd843314856, 2'd0};
        vecs[9] = '{1'b1, 32'd843314857, 32'd0, 2'd0};

        reset = 1'b1; in_valid = 1'b0; in_angle = '0; in_op = 1'b0; out_ready = 1'b0;
        core_ready = 1'b0; core_done = 1'b0; core_value = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_value", out_value, 32'd0);
        chk("rst_out_status", {30'b0, out_status}, 32'd0);
        chk("rst_core_start", {31'b0, core_start}, 32'd0);
        chk("rst_core_angle", core_angle, 32'd0);

        for (int i = 0; i < 10; i++) begin
            rval = 32'h1234_5678 ^ i;
            do_request(vecs[i].op, vecs[i].ang, 0, 1, 1'b0, rval, 0, 1'b0, 1'b0, '0,
                       ga, st, gv, gs, lt, isn);
            chk("vec_status", {30'b0, gs}, {30'b0, vecs[i].exp_status});
            if (vecs[i].exp_status == 2'd0) begin
                chk("vec_core_angle", ga, vecs[i].exp_angle);
                chk("vec_starts", st, 1);
                chk("vec_value", gv, rval);
                chk("vec_latency", lt, 5);
            end else begin
                chk("vec_range_starts", st, 0);
                chk("vec_range_value", gv, 32'd0);
                chk("vec_range_latency", lt, 2);
            end
        end

        // Done held high from before issue never produces an edge.
        do_request(1'b0, 32'd0, 0, -1, 1'b1, 32'hdead_beef, 0, 1'b0, 1'b0, '0,
                   ga, st, gv, gs, lt, isn);
        chk("to_status", {30'b0, gs}, 32'd2);
        chk("to_value", gv, 32'd0);
        chk("to_issue_to_valid", lt - isn, TIMEOUT + 1);

        // Done edge in the last counted cycle wins over the timeout; one cycle later loses.
        do_request(1'b0, 32'd0, 0, TIMEOUT, 1'b0, 32'h0bad_cafe, 0, 1'b0, 1'b0, '0,
                   ga, st, gv, gs, lt, isn);
        chk("edge_vs_to_status", {30'b0, gs}, 32'd0);
        chk("edge_vs_to_value", gv, 32'h0bad_cafe);
        do_request(1'b0, 32'd0, 0, TIMEOUT + 1, 1'b0, 32'h0bad_cafe, 0, 1'b0, 1'b0, '0,
                   ga, st, gv, gs, lt, isn);
        chk("late_edge_status", {30'b0, gs}, 32'd2);

        // Output stall with a second request waiting; it is accepted only after the handshake.
        do_request(1'b0, 32'd1264972285, 2, 3, 1'b0, 32'h1111_2222, 5, 1'b1, 1'b1, 32'd0,
                   ga, st, gv, gs, lt, isn);
        chk("stall_value", gv, 32'h1111_2222);
        chk("stall_latency", lt, 4 + 2 + 3);
        do_request(1'b1, 32'd0, 0, 1, 1'b0, 32'h3333_4444, 0, 1'b0, 1'b0, '0,
                   ga, st, gv, gs, lt, isn);
        chk("chained_core_angle", ga, 32'd843314856);
        chk("chained_latency", lt, 5);

        // Reset while waiting for done abandons the request.
        in_valid = 1'b1; in_op = 1'b0; in_angle = 32'd1264972285; core_ready = 1'b1;
        core_done = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            if (core_start) seen = 1;
            else @(negedge clk);
        end
        chk("rst_seq_start_seen", seen, 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_core_start", {31'b0, core_start}, 32'd0);
        chk("mid_rst_core_angle", core_angle, 32'd0);
        @(negedge clk);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid || !in_ready) seen++;
        end
        chk("late_done_ignored", seen, 0);

        for (int i = 0; i < 40; i++) begin
            rop  = $urandom_range(1, 0) == 1;
            rval = $urandom;
            rd   = $urandom_range(3, 0);
            dd   = $urandom_range(5, 1);
            if ($urandom_range(3, 0) == 0) ra = $urandom;
            else ra = 32'(longint'($urandom_range(32'd3373259426, 32'd0)) - PI_Q);
            sang = longint'($signed(ra));
            ok   = ref_in_range(sang);
            do_request(rop, ra, rd, dd, 1'b0, rval, $urandom_range(2, 0), 1'b0, 1'b0, '0,
                       ga, st, gv, gs, lt, isn);
            if (ok) begin
                chk("rnd_core_angle", ga, 32'(ref_fold(rop, sang)));
                chk("rnd_status", {30'b0, gs}, 32'd0);
                chk("rnd_value", gv, rval);
                chk("rnd_starts", st, 1);
                chk("rnd_latency", lt, 4 + rd + dd);
            end else begin
                chk("rnd_range_status", {30'b0, gs}, 32'd1);
                chk("rnd_range_value", gv, 32'd0);
                chk("rnd_range_starts", st, 0);
                chk("rnd_range_latency", lt, 2);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
